// File: rtl/axi_write_arbiter_if.sv
// ============================================================================
//  Module      : axi_write_arbiter_if
//  Description : Bundle of requester-side and slave-side AXI4-Lite write
//                signals shared by the write arbiter and its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_write_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  // Requester side
  logic [NUM_MASTERS*ADDR_W-1:0] m_awaddr;
  logic [NUM_MASTERS-1:0]        m_awvalid;
  logic [NUM_MASTERS-1:0]        m_awready;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]        m_wvalid;
  logic [NUM_MASTERS-1:0]        m_wready;
  logic [NUM_MASTERS*2-1:0]      m_bresp;
  logic [NUM_MASTERS-1:0]        m_bvalid;
  logic [NUM_MASTERS-1:0]        m_bready;

  // Shared slave bus
  logic [ADDR_W-1:0]             s_awaddr;
  logic                          s_awvalid;
  logic                          s_awready;
  logic [DATA_W-1:0]             s_wdata;
  logic                          s_wvalid;
  logic                          s_wready;
  logic [1:0]                    s_bresp;
  logic                          s_bvalid;
  logic                          s_bready;

  // Status
  logic [NUM_MASTERS-1:0]        grant;
  logic                          busy;

  // Arbiter view: it masters the shared slave bus and serves the requesters.
  modport master (
    input  m_awaddr, m_awvalid, m_wdata, m_wvalid, m_bready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    output m_awready, m_wready, m_bresp, m_bvalid,
    output s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
    output grant, busy
  );

  // Environment view: requesters plus the downstream slave.
  modport slave (
    output m_awaddr, m_awvalid, m_wdata, m_wvalid, m_bready,
    output s_awready, s_wready, s_bresp, s_bvalid,
    input  m_awready, m_wready, m_bresp, m_bvalid,
    input  s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
    input  grant, busy
  );
endinterface

`default_nettype wire

// File: rtl/axi_write_arbiter.sv
// ============================================================================
//  Module      : axi_write_arbiter
//  Description : Round-robin arbiter sharing one AXI4-Lite write channel set
//                among NUM_MASTERS requesters, one transaction at a time,
//                with a watchdog that turns a hung slave into SLVERR.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_write_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire logic          clk,
  input  wire logic          rst,   // asynchronous, active-low
  axi_write_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic [TMR_W-1:0]       timer_q, timer_d;

  logic                   pick_vld;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       cand;

  logic                   s_awvalid_w, s_wvalid_w, s_bready_w;
  logic                   m_awready_en, m_wready_en, m_bvalid_en;
  logic [1:0]             m_bresp_w;
  logic                   aw_hs, w_hs, b_hs, xfer_done, tmr_expired;

  // Index arithmetic modulo NUM_MASTERS (works for non-power-of-two counts).
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
    return IDX_W'(s);
  endfunction

  // Round-robin pick: first master with m_awvalid scanning upward from rr_ptr.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = wrap_add(rr_ptr_q, k);
      if (!pick_vld && bus.m_awvalid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // State register and transaction bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      rr_ptr_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      rr_ptr_q  <= rr_ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      timer_q   <= timer_d;
    end
  end

  // Next-state logic and channel steering toward the granted master.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    rr_ptr_d     = rr_ptr_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    timer_d      = timer_q;
    s_awvalid_w  = 1'b0;
    s_wvalid_w   = 1'b0;
    s_bready_w   = 1'b0;
    m_awready_en = 1'b0;
    m_wready_en  = 1'b0;
    m_bvalid_en  = 1'b0;
    m_bresp_w    = 2'b00;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;
    b_hs         = 1'b0;
    xfer_done    = 1'b0;
    tmr_expired  = (timer_q == TMR_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_XFER;
          grant_d = NUM_MASTERS'(1) << pick_idx;
          gidx_d  = pick_idx;
          timer_d = '0;
        end
      end

      ST_XFER: begin
        s_awvalid_w  = bus.m_awvalid[gidx_q] & ~aw_done_q;
        s_wvalid_w   = bus.m_wvalid[gidx_q]  & ~w_done_q;
        m_awready_en = bus.s_awready & ~aw_done_q;
        m_wready_en  = bus.s_wready  & ~w_done_q;
        aw_hs        = s_awvalid_w & bus.s_awready;
        w_hs         = s_wvalid_w  & bus.s_wready;
        xfer_done    = (aw_done_q | aw_hs) & (w_done_q | w_hs);
        timer_d      = timer_q + TMR_W'(1);
        if (xfer_done || tmr_expired) begin
          state_d   = xfer_done ? ST_RESP : ST_ERR;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q  | w_hs;
        end
      end

      ST_RESP: begin
        s_bready_w  = bus.m_bready[gidx_q];
        m_bvalid_en = bus.s_bvalid;
        m_bresp_w   = bus.s_bresp;
        b_hs        = bus.s_bvalid & bus.m_bready[gidx_q];
        timer_d     = timer_q + TMR_W'(1);
        if (b_hs) begin
          // A response in the expiry cycle still completes normally.
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = wrap_add(gidx_q, 1);
        end else if (tmr_expired) begin
          state_d = ST_ERR;
        end
      end

      ST_ERR: begin
        // Slave is ignored here; the master gets a synthesized SLVERR.
        m_bvalid_en = 1'b1;
        m_bresp_w   = 2'b10;
        if (bus.m_bready[gidx_q]) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = wrap_add(gidx_q, 1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Slave-bus payload is zeroed outside XFER so nothing leaks while idle.
  assign bus.s_awaddr  = (state_q == ST_XFER) ? bus.m_awaddr[gidx_q*ADDR_W +: ADDR_W] : '0;
  assign bus.s_wdata   = (state_q == ST_XFER) ? bus.m_wdata[gidx_q*DATA_W +: DATA_W]  : '0;
  assign bus.s_awvalid = s_awvalid_w;
  assign bus.s_wvalid  = s_wvalid_w;
  assign bus.s_bready  = s_bready_w;

  // grant_q is one-hot (or zero), so it directly selects the owning master.
  assign bus.m_awready = m_awready_en ? grant_q : '0;
  assign bus.m_wready  = m_wready_en  ? grant_q : '0;
  assign bus.m_bvalid  = m_bvalid_en  ? grant_q : '0;

  // Per-master response code, zero for every master not owning the bus.
  always_comb begin
    bus.m_bresp = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      bus.m_bresp[i*2 +: 2] = grant_q[i] ? m_bresp_w : 2'b00;
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/axi_write_arbiter.md
Name: axi_write_arbiter

Overview:
- Shares one AXI4-Lite write channel set (AW, W, B) between NUM_MASTERS requesters, e.g. top_counter plus a future debug/UART master, ahead of the slaves selected by COMPONENT_ID in the address.
- Round-robin, one outstanding transaction at a time.
- Watchdog converts a hung slave into an SLVERR response so no master deadlocks.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4).
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width.
- TIMEOUT_CYCLES, 1024, cycles in any busy state before the arbiter aborts with SLVERR.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted at 0).
- m_awaddr  input  NUM_MASTERS*ADDR_W  master write addresses, master i at slice [i*ADDR_W +: ADDR_W].
- m_awvalid  input  NUM_MASTERS  per-master address valid.
- m_awready  output  NUM_MASTERS  per-master address ready.
- m_wdata  input  NUM_MASTERS*DATA_W  master write data.
- m_wvalid  input  NUM_MASTERS  per-master data valid.
- m_wready  output  NUM_MASTERS  per-master data ready.
- m_bresp  output  NUM_MASTERS*2  per-master write response.
- m_bvalid  output  NUM_MASTERS  per-master response valid.
- m_bready  input  NUM_MASTERS  per-master response ready.
- s_awaddr  output  ADDR_W  to slave bus.
- s_awvalid  output  1  to slave bus.
- s_awready  input  1  from slave bus.
- s_wdata  output  DATA_W  to slave bus.
- s_wvalid  output  1  to slave bus.
- s_wready  input  1  from slave bus.
- s_bresp  input  2  from slave bus.
- s_bvalid  input  1  from slave bus.
- s_bready  output  1  to slave bus.
- grant  output  NUM_MASTERS  one-hot registered owner; 0 when idle.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE, grant=0, rr_ptr=0, aw_done=w_done=0, timer=0. All s_*valid, s_bready, m_*ready and m_bvalid are 0.
- FSM states: IDLE, XFER, RESP, ERR.
- IDLE:
  - Requesters are masters with m_awvalid=1.
  - Pick the first requester scanning from rr_ptr upward with wrap.
  - Register grant and go to XFER on the next edge. Arbitration latency is 1 cycle, so the slave sees s_awvalid no earlier than the cycle after the master raises m_awvalid.
  - m_wvalid alone does not request.
- XFER:
  - s_awaddr/s_awvalid and s_wdata/s_wvalid are muxed combinationally from the granted master.
  - s_awvalid is gated low once aw_done=1; s_wvalid is gated low once w_done=1.
  - m_awready[g]=s_awready & ~aw_done; m_wready[g]=s_wready & ~w_done.
  - aw_done sets on an AW handshake; w_done sets on a W handshake. Both may occur in the same cycle, in either order.
  - When both handshakes are complete (registered or current cycle), go to RESP. Clear aw_done and w_done on exit.
- RESP:
  - s_bready=m_bready[g]; m_bvalid[g]=s_bvalid; m_bresp[g]=s_bresp.
  - On the B handshake: go to IDLE, rr_ptr=(g+1) mod NUM_MASTERS, grant=0.
  - The next grant is issued at the earliest 1 cycle later, so there is no back-to-back bus reuse in the handshake cycle.
- ERR:
  - All s_* valids and s_bready are 0.
  - m_bvalid[g]=1 and m_bresp[g]=2'b10 until m_bready[g]; then behave as the RESP exit (IDLE, rr_ptr advance).
- Non-granted masters: all ready/valid outputs 0, bresp 2'b00.
- Watchdog:
  - timer clears on entry to XFER and increments each cycle in XFER/RESP.
  - When timer==TIMEOUT_CYCLES-1 and the exit condition is not met this cycle, go to ERR.
  - A slave response arriving in that same cycle wins.
  - Late slave handshakes after the abort are ignored (s_*ready/bvalid are don't-care while in ERR).
- A master dropping m_awvalid before the handshake is a protocol violation; the arbiter holds grant regardless.
- Reset asserted mid-transaction: immediate return to reset values; the slave sees valid fall asynchronously.

Test Plan:
- Single master 0 writes addr 0x7F00_0004, data 0x1234, slave ready at once, bresp 00 -> s_awvalid rises 1 cycle after request; grant=01; m_bvalid[0] pulses; busy falls; rr_ptr=1.
- Both masters request in the same cycle, 4 consecutive writes each -> grant order 0,1,0,1,...; s_awaddr always matches the granted master; no transaction is lost.
- Slave accepts W 3 cycles before AW, then AW and W in the same cycle on the next transfer -> exactly one handshake each; RESP entered the cycle after the later handshake.
- Slave never asserts s_bvalid, TIMEOUT_CYCLES=16 -> ERR at cycle 16 after XFER entry; m_bresp=2'b10 to the granted master; arbiter returns to IDLE after m_bready.
- Master 1 holds m_bready=0 for 5 cycles in RESP -> s_bready=0 for those cycles; master 0 request stays pending; grant switches only after the B handshake plus the 1-cycle idle.
- rst pulled low during XFER -> all outputs 0 the same cycle; after release the first request is granted from rr_ptr=0.
